memorystage1: RTL and testbench

Pipeline stage 1 of the core: it sits between decode/register-read (stage 0) and `registersstage2`, and performs all data-memory traffic. It computes effective addresses, checks alignment, and runs the request/acknowledge bus cycle with a timeout. It stalls the upstream stage while a cycle is outstanding, then forwards the instruction and raw read data to stage 2. Extension of read data is stage 2's job; this block passes bus data through unmodified.

---
 rtl/memorystage1_pkg.sv | 22 ++
 rtl/memorystage1_if.sv | 24 ++
 rtl/memorystage1_memaddrgen.sv | 23 ++
 rtl/memorystage1.sv | 164 ++++++++++++++++
 tb/tb_memorystage1.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/memorystage1_pkg.sv
// Shared opcode, cycle-width and instruction helpers for the memory stage.
package memorystage1_pkg;

    localparam logic [4:0] OPCODE_NOP   = 5'h00;
    localparam logic [4:0] OPCODE_LOADI = 5'h01;
    localparam logic [4:0] OPCODE_LOAD  = 5'h02;
    localparam logic [4:0] OPCODE_STORE = 5'h03;
    localparam logic [4:0] OPCODE_HALT  = 5'h1F;

    typedef logic [1:0] t_cycle_width;

    localparam t_cycle_width CW_BYTE = 2'd0;
    localparam t_cycle_width CW_WORD = 2'd1;
    localparam t_cycle_width CW_LONG = 2'd2;

    localparam logic [31:0] INSTR_NOP = {OPCODE_NOP, 27'h0};

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OPCODE_LOAD) || (op == OPCODE_STORE);
    endfunction

endpackage

// File: rtl/memorystage1_if.sv
// Data-memory bus between the memory stage (master) and the memory slave.
interface memorystage1_if;
    import memorystage1_pkg::*;

    logic [31:0]  bus_address;
    logic [31:0]  bus_data_out;
    t_cycle_width bus_width;
    logic         bus_read;
    logic         bus_write;
    logic [31:0]  bus_data_in;
    logic         bus_ack;
    logic         bus_error;

    modport master (
        output bus_address, bus_data_out, bus_width, bus_read, bus_write,
        input  bus_data_in, bus_ack, bus_error
    );

    modport slave (
        input  bus_address, bus_data_out, bus_width, bus_read, bus_write,
        output bus_data_in, bus_ack, bus_error
    );

endinterface

// File: rtl/memorystage1_memaddrgen.sv
// Effective address (base + sign-extended offset) and alignment check.
module memaddrgen
    import memorystage1_pkg::*;
(
    input  logic [31:0]  base_i,
    input  logic [15:0]  offset_i,
    input  t_cycle_width width_i,
    output logic [31:0]  address_o,
    output logic         misaligned_o
);

    assign address_o = base_i + {{16{offset_i[15]}}, offset_i};

    always_comb begin
        misaligned_o = 1'b0;
        case (width_i)
            CW_WORD: misaligned_o = address_o[0];
            CW_LONG: misaligned_o = |address_o[1:0];
            default: misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/memorystage1.sv
// Memory pipeline stage: issues one bus cycle per LOAD/STORE, stalls stage 0
// while it is outstanding, and forwards the instruction plus raw read data.
module memorystage1
    import memorystage1_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          inbound_instruction,
    output logic [3:0]           address_index,
    input  logic [31:0]          address_data,
    output logic [3:0]           store_index,
    input  logic [31:0]          store_data,
    memorystage1_if.master       bus,
    output logic                 stall,
    output logic                 fault,
    output logic [31:0]          fault_address,
    output logic                 halting,
    output logic [31:0]          outbound_instruction,
    output logic [31:0]          outbound_data
);

    typedef logic [0:0] t_mem_state;
    localparam t_mem_state ST_IDLE   = 1'b0;
    localparam t_mem_state ST_ACCESS = 1'b1;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    t_mem_state   state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    t_cycle_width width_q, width_d;
    logic         read_q, read_d;
    logic         write_q, write_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_addr_q, fault_addr_d;
    logic         halting_q, halting_d;
    logic [31:0]  out_instr_q, out_instr_d;
    logic [31:0]  out_data_q, out_data_d;

    logic [4:0]   opcode;
    logic [31:0]  eff_addr;
    logic         misaligned;
    logic         unused_bit;

    assign opcode        = inbound_instruction[31:27];
    assign address_index = inbound_instruction[19:16];
    assign store_index   = inbound_instruction[23:20];
    assign unused_bit    = inbound_instruction[24];

    memaddrgen u_addrgen (
        .base_i       (address_data),
        .offset_i     (inbound_instruction[15:0]),
        .width_i      (inbound_instruction[26:25]),
        .address_o    (eff_addr),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        instr_d      = instr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        width_d      = width_q;
        read_d       = read_q;
        write_d      = write_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;
        halting_d    = halting_q;
        out_instr_d  = out_instr_q;
        out_data_d   = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_op(opcode)) begin
                    out_instr_d = INSTR_NOP;
                    if (misaligned) begin
                        fault_d      = 1'b1;
                        fault_addr_d = eff_addr;
                    end else begin
                        addr_d  = eff_addr;
                        width_d = inbound_instruction[26:25];
                        if (opcode == OPCODE_STORE) wdata_d = store_data;
                        read_d  = (opcode == OPCODE_LOAD);
                        write_d = (opcode == OPCODE_STORE);
                        cnt_d   = 8'd0;
                        instr_d = inbound_instruction;
                        state_d = ST_ACCESS;
                    end
                end else begin
                    out_instr_d = inbound_instruction;
                    if (opcode == OPCODE_HALT) halting_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                out_instr_d = INSTR_NOP;
                cnt_d       = cnt_q + 8'd1;
                // Error beats ack; a genuine ack on the last allowed cycle still completes.
                if (bus.bus_error || (!bus.bus_ack && cnt_q == TO_LAST)) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    state_d      = ST_IDLE;
                    fault_d      = 1'b1;
                    fault_addr_d = addr_q;
                end else if (bus.bus_ack) begin
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    state_d     = ST_IDLE;
                    out_instr_d = instr_q;
                    if (instr_q[31:27] == OPCODE_LOAD) out_data_d = bus.bus_data_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            instr_q      <= INSTR_NOP;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            width_q      <= CW_BYTE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            halting_q    <= 1'b0;
            out_instr_q  <= INSTR_NOP;
            out_data_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            instr_q      <= instr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            width_q      <= width_d;
            read_q       <= read_d;
            write_q      <= write_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            halting_q    <= halting_d;
            out_instr_q  <= out_instr_d;
            out_data_q   <= out_data_d;
        end
    end

    assign stall                = (state_q == ST_ACCESS);
    assign bus.bus_address      = addr_q;
    assign bus.bus_data_out     = wdata_q;
    assign bus.bus_width        = width_q;
    assign bus.bus_read         = read_q;
    assign bus.bus_write        = write_q;
    assign fault                = fault_q;
    assign fault_address        = fault_addr_q;
    assign halting              = halting_q;
    assign outbound_instruction = out_instr_q;
    assign outbound_data        = out_data_q;

endmodule

// File: tb/tb_memorystage1.sv
// Randomized bench for memorystage1 with a transaction-timeline reference model.
module tb_memorystage1;
    import memorystage1_pkg::*;

    localparam int TO = 4;
    localparam int M_ACK = 0, M_ERR = 1, M_NONE = 2, M_BOTH = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inbound_instruction, address_data, store_data;
    logic [3:0]  address_index, store_index;
    logic        stall, fault, halting;
    logic [31:0] fault_address, outbound_instruction, outbound_data;

    memorystage1_if bus();

    memorystage1 #(.TIMEOUT_CYCLES(TO)) dut (
        .clock                (clock),
        .reset                (reset),
        .inbound_instruction  (inbound_instruction),
        .address_index        (address_index),
        .address_data         (address_data),
        .store_index          (store_index),
        .store_data           (store_data),
        .bus                  (bus),
        .stall                (stall),
        .fault                (fault),
        .fault_address        (fault_address),
        .halting              (halting),
        .outbound_instruction (outbound_instruction),
        .outbound_data        (outbound_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle.
    logic [31:0] e_out_instr, e_out_data, e_fault_addr, e_addr, e_wdata;
    logic        e_fault, e_halting, e_stall, e_read, e_write;
    logic [1:0]  e_width;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_reset_exp();
        e_out_instr = INSTR_NOP; e_out_data = 32'h0; e_fault_addr = 32'h0;
        e_addr = 32'h0; e_wdata = 32'h0; e_fault = 1'b0; e_halting = 1'b0;
        e_stall = 1'b0; e_read = 1'b0; e_write = 1'b0; e_width = CW_BYTE;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("outbound_instruction", outbound_instruction, e_out_instr);
            check("outbound_data", outbound_data, e_out_data);
            check("fault", {31'h0, fault}, {31'h0, e_fault});
            check("fault_address", fault_address, e_fault_addr);
            check("halting", {31'h0, halting}, {31'h0, e_halting});
            check("stall", {31'h0, stall}, {31'h0, e_stall});
            check("bus_read", {31'h0, bus.bus_read}, {31'h0, e_read});
            check("bus_write", {31'h0, bus.bus_write}, {31'h0, e_write});
            check("bus_address", bus.bus_address, e_addr);
            check("bus_data_out", bus.bus_data_out, e_wdata);
            check("bus_width", {30'h0, bus.bus_width}, {30'h0, e_width});
            check("address_index", {28'h0, address_index}, {28'h0, inbound_instruction[19:16]});
            check("store_index", {28'h0, store_index}, {28'h0, inbound_instruction[23:20]});
        end
    end

    task automatic to_neg();
        @(negedge clock); #1;
    endtask

    task automatic to_pos();
        @(posedge clock); #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] w,
                                       input logic [3:0] rd, input logic [3:0] rb,
                                       input logic [15:0] off);
        return {op, w, 1'b0, rd, rb, off};
    endfunction

    task automatic run_other(input logic [31:0] instr);
        inbound_instruction = instr;
        address_data = $urandom; store_data = $urandom;
        bus.bus_ack = 1'($urandom); bus.bus_error = 1'($urandom);
        bus.bus_data_in = $urandom;
        to_neg();
        e_out_instr = instr;
        e_fault = 1'b0;
        if (instr[31:27] == OPCODE_HALT) e_halting = 1'b1;
        to_pos();
        bus.bus_ack = 1'b0; bus.bus_error = 1'b0;
    endtask

    // One LOAD/STORE from presentation to completion; the slave answers
    // in ACCESS cycle index `waits` according to `mode`.
    task automatic run_mem(input logic [31:0] instr, input logic [31:0] base,
                           input logic [31:0] sdata, input int mode, input int waits,
                           input logic [31:0] rdata, output int stall_cnt, output int strobe_cnt);
        logic [4:0]  op;
        logic [1:0]  w;
        logic [31:0] addr;
        logic        mis, ack_now, err_now, done;
        op   = instr[31:27];
        w    = instr[26:25];
        addr = base + {{16{instr[15]}}, instr[15:0]};
        mis  = (w == CW_WORD && addr[0]) || (w == CW_LONG && addr[1:0] != 2'b00);
        stall_cnt = 0; strobe_cnt = 0;
        inbound_instruction = instr; address_data = base; store_data = sdata;
        bus.bus_ack = 1'($urandom); bus.bus_error = 1'($urandom);
        bus.bus_data_in = $urandom;
        to_neg();
        e_out_instr = INSTR_NOP;
        if (mis) begin
            e_fault = 1'b1; e_fault_addr = addr;
        end else begin
            e_fault = 1'b0; e_read = (op == OPCODE_LOAD); e_write = (op == OPCODE_STORE);
            e_addr = addr; e_width = w; e_stall = 1'b1;
            if (op == OPCODE_STORE) e_wdata = sdata;
        end
        to_pos();
        bus.bus_ack = 1'b0; bus.bus_error = 1'b0;
        if (!mis) begin
            done = 1'b0;
            for (int k = 0; k < 64 && !done; k++) begin
                ack_now = (mode == M_ACK || mode == M_BOTH) && k == waits;
                err_now = (mode == M_ERR || mode == M_BOTH) && k == waits;
                bus.bus_ack = ack_now; bus.bus_error = err_now;
                bus.bus_data_in = ack_now ? rdata : $urandom;
                stall_cnt  += int'(stall);
                strobe_cnt += int'(bus.bus_read | bus.bus_write);
                to_neg();
                e_fault = 1'b0;
                if (err_now || (!ack_now && k == TO - 1)) begin
                    e_fault = 1'b1; e_fault_addr = addr;
                    e_read = 1'b0; e_write = 1'b0; e_stall = 1'b0; done = 1'b1;
                end else if (ack_now) begin
                    e_out_instr = instr;
                    if (op == OPCODE_LOAD) e_out_data = rdata;
                    e_read = 1'b0; e_write = 1'b0; e_stall = 1'b0; done = 1'b1;
                end
                to_pos();
                bus.bus_ack = 1'b0; bus.bus_error = 1'b0;
            end
            if (!done) check("access_bound", 32'h0, 32'h1);
        end
    endtask

    task automatic reset_mid_access();
        inbound_instruction = mk(OPCODE_LOAD, CW_LONG, 4'd3, 4'd4, 16'h0010);
        address_data = 32'h0000_0100;
        to_neg();
        e_out_instr = INSTR_NOP; e_fault = 1'b0; e_read = 1'b1; e_write = 1'b0;
        e_addr = 32'h0000_0110; e_width = CW_LONG; e_stall = 1'b1;
        to_pos();
        #2 reset = 1'b1;
        #1;
        check("rst_read_drop", {31'h0, bus.bus_read}, 32'h0);
        check("rst_stall_drop", {31'h0, stall}, 32'h0);
        check("rst_halting", {31'h0, halting}, 32'h0);
        check("rst_out_instr", outbound_instruction, 32'h0000_0000);
        set_reset_exp();
        to_pos();
        reset = 1'b0;
    endtask

    initial begin : main
        int sc, bc, mode, waits;
        logic [31:0] instr, base;
        logic [4:0]  op;
        logic [15:0] off;
        logic [4:0]  others [5];
        others[0] = OPCODE_NOP; others[1] = OPCODE_LOADI; others[2] = 5'h05;
        others[3] = 5'h10; others[4] = OPCODE_HALT;

        reset = 1'b1;
        inbound_instruction = INSTR_NOP; address_data = 32'h0; store_data = 32'h0;
        bus.bus_data_in = 32'h0; bus.bus_ack = 1'b0; bus.bus_error = 1'b0;
        set_reset_exp();
        #1 chk_en = 1'b1;
        to_pos(); to_pos();
        check("reset_out_instr", outbound_instruction, 32'h0000_0000);
        check("reset_width", {30'h0, bus.bus_width}, 32'h0);
        reset = 1'b0;

        // LOADI R1 then NOP, forwarded on consecutive cycles
        run_other(mk(OPCODE_LOADI, 2'd0, 4'd1, 4'd0, 16'h1234));
        check("loadi_fwd", outbound_instruction, 32'h0810_1234);
        run_other(INSTR_NOP);

        // LOAD LONG 0x1000 - 4 with two wait states
        instr = mk(OPCODE_LOAD, CW_LONG, 4'd2, 4'd1, 16'hFFFC);
        run_mem(instr, 32'h0000_1000, 32'h0, M_ACK, 2, 32'hDEAD_BEEF, sc, bc);
        check("load_stall_cycles", sc, 3);
        check("load_read_cycles", bc, 3);
        check("load_bus_address", bus.bus_address, 32'h0000_0FFC);
        check("load_data", outbound_data, 32'hDEAD_BEEF);
        check("load_fwd", outbound_instruction, 32'h1421_FFFC);

        // misaligned STORE WORD to 0x2001
        run_mem(mk(OPCODE_STORE, CW_WORD, 4'd5, 4'd6, 16'h0001), 32'h0000_2000,
                32'h5555_AAAA, M_ACK, 0, 32'h0, sc, bc);
        check("mis_fault", {31'h0, fault}, 32'h1);
        check("mis_fault_addr", fault_address, 32'h0000_2001);
        check("mis_no_strobe", {31'h0, bus.bus_write}, 32'h0);

        // STORE BYTE with no answer: times out after TO cycles
        run_mem(mk(OPCODE_STORE, CW_BYTE, 4'd7, 4'd8, 16'h0003), 32'h0000_3000,
                32'h0000_00A5, M_NONE, 0, 32'h0, sc, bc);
        check("to_write_cycles", bc, TO);
        check("to_fault", {31'h0, fault}, 32'h1);
        check("to_stall_release", {31'h0, stall}, 32'h0);
        check("to_fault_addr", fault_address, 32'h0000_3003);

        // ack and error together on a LOAD: a fault, read data untouched
        run_mem(mk(OPCODE_LOAD, CW_WORD, 4'd9, 4'd1, 16'h0002), 32'h0000_4000,
                32'h0, M_BOTH, 1, 32'h1111_2222, sc, bc);
        check("both_fault", {31'h0, fault}, 32'h1);
        check("both_data_kept", outbound_data, 32'hDEAD_BEEF);
        check("both_fwd_nop", outbound_instruction, 32'h0000_0000);

        // back-to-back misaligned faults
        run_mem(mk(OPCODE_LOAD, CW_LONG, 4'd1, 4'd2, 16'h0002), 32'h0, 32'h0, M_ACK, 0, 32'h0, sc, bc);
        run_mem(mk(OPCODE_LOAD, CW_LONG, 4'd1, 4'd2, 16'h0001), 32'h0, 32'h0, M_ACK, 0, 32'h0, sc, bc);

        // zero-wait-state load
        run_mem(mk(OPCODE_LOAD, CW_BYTE, 4'd3, 4'd2, 16'h0007), 32'h0000_5000, 32'h0,
                M_ACK, 0, 32'hCAFE_F00D, sc, bc);
        check("zws_stall_cycles", sc, 1);

        // HALT is forwarded and sticks
        run_other(mk(OPCODE_HALT, 2'd0, 4'd0, 4'd0, 16'h0));
        check("halt_set", {31'h0, halting}, 32'h1);
        run_other(INSTR_NOP);
        check("halt_sticky", {31'h0, halting}, 32'h1);

        reset_mid_access();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                op = others[$urandom_range(0, 4)];
                if (op == OPCODE_HALT && $urandom_range(0, 3) != 0) op = OPCODE_LOADI;
                run_other({op, 27'($urandom)});
            end else begin
                op    = $urandom_range(0, 1) ? OPCODE_LOAD : OPCODE_STORE;
                base  = $urandom;
                if ($urandom_range(0, 1)) base[1:0] = 2'b00;
                off   = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 8) * 4);
                instr = mk(op, 2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom), off);
                case ($urandom_range(0, 19))
                    0, 1, 2:    mode = M_ERR;
                    3, 4, 5:    mode = M_NONE;
                    6, 7:       mode = M_BOTH;
                    default:    mode = M_ACK;
                endcase
                waits = $urandom_range(0, TO + 1);
                run_mem(instr, base, $urandom, mode, waits, $urandom, sc, bc);
            end
        end

        to_pos();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
